// File: rtl/uart_pkg.sv
// Shared register map, sequencer FSM states and frame timing helper
// for the UART register-port sequencer.
package uart_pkg;

  typedef enum logic [3:0] {
    UART_REG_STATUS = 4'h0,
    UART_REG_RXDATA = 4'h1,
    UART_REG_TXCTRL = 4'h2,
    UART_REG_TXDATA = 4'h3
  } uart_reg_e;

  typedef enum logic [2:0] {
    SEQ_IDLE,
    SEQ_TX_WR,
    SEQ_ST_REQ,
    SEQ_ST_WAIT,
    SEQ_RD_REQ,
    SEQ_RD_WAIT
  } uart_seq_state_e;

  // Clock cycles one transmitted frame occupies on the line, plus idle guard.
  function automatic int unsigned frame_cycles(
    input int unsigned clock_freq_hz,
    input int unsigned baud_rate,
    input int unsigned data_bits,
    input int unsigned parity_bit,
    input int unsigned stop_bits,
    input int unsigned guard_cycles
  );
    int unsigned bits;
    bits = 32'd1 + data_bits + ((parity_bit != 0) ? 32'd1 : 32'd0) + stop_bits;
    return (clock_freq_hz / baud_rate) * bits + guard_cycles;
  endfunction

endpackage

// File: rtl/uart_seq_fifo.sv
// Synchronous transmit FIFO. ready_o is a registered "not full" so the
// client handshake never sees a combinational path through the pop logic.
module uart_seq_fifo #(
  parameter int unsigned Depth = 16,
  parameter int unsigned Width = 8,
  localparam int unsigned AddrW = $clog2(Depth),
  localparam int unsigned CntW  = $clog2(Depth) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic [CntW-1:0]  count_o,
  output logic             empty_o,
  output logic             ready_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q, count_d;
  logic             ready_q;
  logic             push_en, pop_en;

  // A push is taken only against the registered ready, so a pop at full
  // frees a slot that becomes visible one cycle later.
  assign push_en = push_i & ready_q;
  assign pop_en  = pop_i & (count_q != '0);

  // NOTE: every variable written in always_comb gets a default first; a path
  // that leaves it unassigned would infer a latch.
  always_comb begin
    count_d = count_q;
    unique case ({push_en, pop_en})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: storage has no reset; the pointers and count reset instead, so
  // stale entries are unreachable and the array can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q] <= data_i;
  end

  // NOTE: sequential state uses non-blocking assignment so every register
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b0;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + AddrW'(1);
      if (pop_en)  rd_ptr_q <= rd_ptr_q + AddrW'(1);
      count_q <= count_d;
      ready_q <= (count_d != CntW'(Depth));
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);
  assign ready_o = ready_q;

endmodule

// File: rtl/uart_sequencer.sv
// Drives the UART register port: paced transmit writes from a FIFO and
// receive-status polling that drains bytes into a valid/ready stream.
module uart_sequencer
  import uart_pkg::*;
#(
  parameter int unsigned ClockFreqHz  = 10000000,
  parameter int unsigned BaudRate     = 9600,
  parameter int unsigned DataBitsSize = 8,
  parameter int unsigned ParityBit    = 0,
  parameter int unsigned StopBitsSize = 1,
  parameter int unsigned GuardCycles  = 16,
  parameter int unsigned TxFifoDepth  = 16,
  parameter int unsigned PollInterval = 16,
  localparam int unsigned CntW = $clog2(TxFifoDepth) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            tx_valid,
  input  logic [7:0]      tx_data,
  output logic            tx_ready,
  output logic            rx_valid,
  output logic [7:0]      rx_data,
  input  logic            rx_ready,
  output logic [CntW-1:0] tx_fifo_count,
  output logic            tx_busy,
  output logic [3:0]      u_addr,
  output logic [7:0]      u_wdata,
  output logic            u_addr_strobe,
  input  logic [7:0]      u_data
);

  localparam int unsigned FrameCycles = frame_cycles(ClockFreqHz, BaudRate, DataBitsSize,
                                                     ParityBit, StopBitsSize, GuardCycles);
  localparam int unsigned PacerW = $clog2(FrameCycles + 1);
  localparam int unsigned PollW  = $clog2(PollInterval + 1);
  localparam logic [PacerW-1:0] PacerLoad = PacerW'(FrameCycles - 1);
  localparam logic [PollW-1:0]  PollLoad  = PollW'(PollInterval - 1);

  uart_seq_state_e   state_q, state_d;
  logic [PacerW-1:0] pacer_q, pacer_d;
  logic [PollW-1:0]  poll_q, poll_d;
  logic              rx_valid_q, rx_valid_d;
  logic [7:0]        rx_data_q, rx_data_d;
  uart_reg_e         u_addr_q, u_addr_d;
  logic [7:0]        u_wdata_q, u_wdata_d;
  logic              u_strobe_q, u_strobe_d;
  logic              last_tx_q, last_tx_d;
  logic              fifo_pop, fifo_empty;
  logic [7:0]        fifo_head;
  logic              tx_due, poll_due;

  uart_seq_fifo #(
    .Depth (TxFifoDepth),
    .Width (8)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (tx_valid),
    .data_i  (tx_data),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .count_o (tx_fifo_count),
    .empty_o (fifo_empty),
    .ready_o (tx_ready)
  );

  assign tx_due   = !fifo_empty && (pacer_q == '0);
  assign poll_due = (poll_q == '0) && !rx_valid_q;

  // Outputs to the UART are decided here and registered, so the strobe is
  // high exactly while the FSM sits in a request state.
  always_comb begin
    state_d    = state_q;
    pacer_d    = (pacer_q != '0) ? pacer_q - PacerW'(1) : pacer_q;
    poll_d     = (poll_q != '0) ? poll_q - PollW'(1) : poll_q;
    rx_valid_d = rx_valid_q & ~rx_ready;
    rx_data_d  = rx_data_q;
    u_addr_d   = u_addr_q;
    u_wdata_d  = u_wdata_q;
    u_strobe_d = 1'b0;
    last_tx_d  = last_tx_q;
    fifo_pop   = 1'b0;
    unique case (state_q)
      SEQ_IDLE: begin
        // When both are due, alternate so neither direction starves.
        if (tx_due && (!poll_due || !last_tx_q)) begin
          state_d    = SEQ_TX_WR;
          u_strobe_d = 1'b1;
          u_addr_d   = UART_REG_TXDATA;
          u_wdata_d  = fifo_head;
          fifo_pop   = 1'b1;
          pacer_d    = PacerLoad;
          last_tx_d  = 1'b1;
        end else if (poll_due) begin
          state_d    = SEQ_ST_REQ;
          u_strobe_d = 1'b1;
          u_addr_d   = UART_REG_STATUS;
          last_tx_d  = 1'b0;
        end
      end
      SEQ_TX_WR:  state_d = SEQ_IDLE;
      SEQ_ST_REQ: state_d = SEQ_ST_WAIT;
      SEQ_ST_WAIT: begin
        if (u_data[0]) begin
          state_d    = SEQ_RD_REQ;
          u_strobe_d = 1'b1;
          u_addr_d   = UART_REG_RXDATA;
        end else begin
          state_d = SEQ_IDLE;
          poll_d  = PollLoad;
        end
      end
      SEQ_RD_REQ: state_d = SEQ_RD_WAIT;
      SEQ_RD_WAIT: begin
        state_d    = SEQ_IDLE;
        rx_data_d  = u_data;
        rx_valid_d = 1'b1;
        poll_d     = PollLoad;
      end
      default: state_d = SEQ_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SEQ_IDLE;
      pacer_q    <= '0;
      poll_q     <= '0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
      u_addr_q   <= UART_REG_STATUS;
      u_wdata_q  <= '0;
      u_strobe_q <= 1'b0;
      last_tx_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pacer_q    <= pacer_d;
      poll_q     <= poll_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
      u_addr_q   <= u_addr_d;
      u_wdata_q  <= u_wdata_d;
      u_strobe_q <= u_strobe_d;
      last_tx_q  <= last_tx_d;
    end
  end

  assign rx_valid      = rx_valid_q;
  assign rx_data       = rx_data_q;
  assign u_addr        = u_addr_q;
  assign u_wdata       = u_wdata_q;
  assign u_addr_strobe = u_strobe_q;
  assign tx_busy       = (tx_fifo_count != '0) || (pacer_q != '0);

endmodule

// File: tb/tb_uart_sequencer.sv
// Scoreboard bench: stimulus queues expected UART writes and received bytes,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_uart_sequencer;

  // 1 MHz / 100 kBd = 10 cycles per bit, 10-bit frame, +16 guard -> 116.
  localparam int FC = 116;

  typedef struct {
    logic [7:0] data;
    int         gap;
  } tx_exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_valid, rx_ready, tx_ready, rx_valid, tx_busy, u_addr_strobe;
  logic [7:0] tx_data, rx_data, u_wdata, u_data;
  logic [4:0] tx_fifo_count;
  logic [3:0] u_addr;

  logic       a_tx_valid, a_tx_ready, a_rx_valid, a_tx_busy, a_strobe;
  logic [7:0] a_tx_data, a_rx_data, a_wdata;
  logic [7:0] a_u_data = 8'hFE;
  logic [2:0] a_count;
  logic [3:0] a_addr;

  tx_exp_t    exp_tx[$];
  logic [7:0] exp_rx[$];
  logic [11:0] alt_q[$];

  int n_vec = 0, n_err = 0, cyc = 0, n_st = 0, last_tx_cyc = 0;
  int rx_gen = 0, rx_taken = 0;
  logic [7:0] rx_byte = 8'h00;
  logic prev_strobe = 1'b0, alt_rec = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_sequencer #(.ClockFreqHz(1000000), .BaudRate(100000)) dut (
    .clk(clk), .rst_n(rst_n), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .tx_fifo_count(tx_fifo_count), .tx_busy(tx_busy), .u_addr(u_addr), .u_wdata(u_wdata),
    .u_addr_strobe(u_addr_strobe), .u_data(u_data));

  // Frame time of one cycle and a poll every cycle: tx and poll are due together.
  uart_sequencer #(.ClockFreqHz(1), .BaudRate(2), .GuardCycles(1), .TxFifoDepth(4),
                   .PollInterval(1)) dut_alt (
    .clk(clk), .rst_n(rst_n), .tx_valid(a_tx_valid), .tx_data(a_tx_data), .tx_ready(a_tx_ready),
    .rx_valid(a_rx_valid), .rx_data(a_rx_data), .rx_ready(1'b1),
    .tx_fifo_count(a_count), .tx_busy(a_tx_busy), .u_addr(a_addr), .u_wdata(a_wdata),
    .u_addr_strobe(a_strobe), .u_data(a_u_data));

  task automatic check(input string name, input logic ok, input logic [31:0] act,
                       input string req);
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: actual 0x%0h, required %s", name, act, req);
    end
  endtask

  // Monitor, scoreboard and UART register model.
  always @(negedge clk) begin
    tx_exp_t e;
    logic [7:0] r;
    if (!rst_n) begin
      prev_strobe = 1'b0;
    end else begin
      if (u_addr_strobe) begin
        check("strobe_back_to_back", !prev_strobe, prev_strobe, "0");
        check("strobe_addr", u_addr != 4'h2, u_addr, "not 2");
        if (u_addr == 4'h0) begin
          n_st++;
          u_data = {7'h55, (rx_gen != rx_taken)};
        end else if (u_addr == 4'h1) begin
          u_data   = rx_byte;
          rx_taken = rx_gen;
        end else if (u_addr == 4'h3) begin
          if (exp_tx.size() == 0) begin
            check("tx_unexpected", 1'b0, u_wdata, "no write");
          end else begin
            e = exp_tx.pop_front();
            check("tx_data", u_wdata == e.data, u_wdata, $sformatf("0x%0h", e.data));
            if (e.gap >= 0)
              check("tx_spacing", (cyc - last_tx_cyc) == e.gap, cyc - last_tx_cyc,
                    $sformatf("%0d", e.gap));
          end
          last_tx_cyc = cyc;
        end
      end
      prev_strobe = u_addr_strobe;
      if (rx_valid && rx_ready) begin
        if (exp_rx.size() == 0) begin
          check("rx_unexpected", 1'b0, rx_data, "no byte");
        end else begin
          r = exp_rx.pop_front();
          check("rx_data", rx_data == r, rx_data, $sformatf("0x%0h", r));
        end
      end
      if (a_strobe) begin
        if (a_addr == 4'h3) alt_rec = 1'b1;
        if (alt_rec && alt_q.size() < 7) alt_q.push_back({a_addr, a_wdata});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input int gap, input bit expect_it);
    int n = 0;
    tx_data  = d;
    tx_valid = 1'b1;
    while (!tx_ready && n < 50) begin
      tick();
      n++;
    end
    if (!tx_ready) begin
      check("push_timeout", 1'b0, n, "tx_ready within 50 cycles");
    end else begin
      if (expect_it) exp_tx.push_back('{d, gap});
      tick();
    end
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while (tx_busy && n < bound) begin
      tick();
      n++;
    end
    check("idle_timeout", !tx_busy, n, $sformatf("idle within %0d cycles", bound));
  endtask

  initial begin
    int n;
    int st_mark;
    logic [7:0]  alt_data;
    logic [11:0] ent;
    tx_valid = 1'b0; tx_data = '0; rx_ready = 1'b0;
    a_tx_valid = 1'b0; a_tx_data = '0;
    u_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_strobe", u_addr_strobe == 1'b0, u_addr_strobe, "0");
    check("rst_rx", {rx_valid, rx_data} == 9'h0, {rx_valid, rx_data}, "0");
    check("rst_tx", {tx_ready, tx_busy, tx_fifo_count} == 7'h0, {tx_ready, tx_busy, tx_fifo_count}, "0");
    check("rst_uart", {u_addr, u_wdata} == 12'h0, {u_addr, u_wdata}, "0");
    rst_n = 1'b1;
    check("ready_before_clk", tx_ready == 1'b0, tx_ready, "0");
    tick();
    check("ready_after_clk", tx_ready == 1'b1, tx_ready, "1");

    // Single byte: prompt write, then busy for the remaining frame.
    push(8'h41, -1, 1'b1);
    tx_valid = 1'b0;
    n = 0;
    while (!u_addr_strobe && n < 10) begin
      tick();
      n++;
    end
    check("tx_latency", u_addr_strobe && n <= 3, n, "<= 3 cycles");
    n = 0;
    while (tx_busy && n < 3 * FC) begin
      n++;
      tick();
    end
    check("tx_busy_len", n == FC - 1, n, $sformatf("%0d", FC - 1));

    // Receive one byte and hold it unconsumed.
    rx_byte = 8'h5A;
    exp_rx.push_back(8'h5A);
    rx_gen++;
    n = 0;
    while (!rx_valid && n < 100) begin
      tick();
      n++;
    end
    check("rx_valid_rise", rx_valid == 1'b1, rx_valid, "1");
    check("rx_hold_data", rx_data == 8'h5A, rx_data, "0x5a");
    st_mark = n_st;

    // Three back-to-back bytes: writes exactly one frame apart.
    push(8'h01, -1, 1'b1);
    push(8'h02, FC, 1'b1);
    push(8'h03, FC, 1'b1);
    tx_valid = 1'b0;
    wait_idle(4 * FC);

    // Fill: one byte goes out, sixteen more fill the FIFO, the next is dropped.
    push(8'h10, -1, 1'b1);
    for (int i = 0; i < 16; i++) push(8'h20 + 8'(i), FC, 1'b1);
    check("full_count", tx_fifo_count == 5'd16, tx_fifo_count, "16");
    check("full_ready", tx_ready == 1'b0, tx_ready, "0");
    tx_data = 8'hEE;
    repeat (5) tick();
    tx_valid = 1'b0;
    check("drop_count", tx_fifo_count == 5'd16, tx_fifo_count, "16");
    check("drop_ready", tx_ready == 1'b0, tx_ready, "0");
    wait_idle(18 * FC);
    check("no_poll_while_held", n_st == st_mark, n_st - st_mark, "0 status polls");

    // Consume the held byte; polling resumes.
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    check("rx_clear", rx_valid == 1'b0, rx_valid, "0");
    n = 0;
    while (n_st == st_mark && n < 50) begin
      tick();
      n++;
    end
    check("poll_resume", n_st != st_mark, n, "status poll within 50 cycles");

    // Reset while waiting for receive data; buffered bytes are dropped.
    push(8'h51, -1, 1'b1);
    push(8'h52, 0, 1'b0);
    push(8'h53, 0, 1'b0);
    tx_valid = 1'b0;
    repeat (5) tick();
    rx_byte = 8'h77;
    rx_gen++;
    n = 0;
    while (!(u_addr_strobe && u_addr == 4'h1) && n < 100) begin
      tick();
      n++;
    end
    check("rd_req_seen", u_addr_strobe && u_addr == 4'h1, n, "addr-1 strobe");
    check("rd_fifo_held", tx_fifo_count == 5'd2, tx_fifo_count, "2");
    tick();
    rst_n = 1'b0;
    #1;
    check("midrst_strobe", u_addr_strobe == 1'b0, u_addr_strobe, "0");
    check("midrst_rx", {rx_valid, rx_data} == 9'h0, {rx_valid, rx_data}, "0");
    check("midrst_fifo", {tx_busy, tx_fifo_count} == 6'h0, {tx_busy, tx_fifo_count}, "0");
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Clean restart.
    push(8'h99, -1, 1'b1);
    tx_valid = 1'b0;
    rx_byte = 8'h3C;
    exp_rx.push_back(8'h3C);
    rx_gen++;
    rx_ready = 1'b1;
    n = 0;
    while (exp_rx.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    check("restart_rx", exp_rx.size() == 0, n, "byte delivered within 100 cycles");
    rx_ready = 1'b0;
    wait_idle(2 * FC);

    // Alternation with tx and poll due together every decision.
    for (int i = 0; i < 4; i++) begin
      a_tx_data  = 8'hA1 + 8'(i);
      a_tx_valid = 1'b1;
      n = 0;
      while (!a_tx_ready && n < 20) begin
        tick();
        n++;
      end
      tick();
    end
    a_tx_valid = 1'b0;
    n = 0;
    while (alt_q.size() < 7 && n < 200) begin
      tick();
      n++;
    end
    check("alt_count", alt_q.size() == 7, alt_q.size(), "7 strobes");
    for (int i = 0; i < 7 && alt_q.size() != 0; i++) begin
      ent = alt_q.pop_front();
      alt_data = 8'hA1 + 8'(i / 2);
      if (i % 2 == 0)
        check("alt_tx", ent == {4'h3, alt_data}, ent, $sformatf("0x3%0h", alt_data));
      else
        check("alt_poll", ent[11:8] == 4'h0, ent[11:8], "0x0");
    end

    check("tx_queue_empty", exp_tx.size() == 0, exp_tx.size(), "0");
    check("rx_queue_empty", exp_rx.size() == 0, exp_rx.size(), "0");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
